pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Program-counter stage of the single-cycle CPU, directly upstream of the instruction ROM. It holds PC and drives the ROM Address. It computes the next PC from the sequential, branch, jump and jr paths. It also owns interrupt and exception vectoring, the kernel-mode bit (PC[31]) and the $k0 save value.

Parameters:
RESET_PC, 32'h8000_0000, PC after reset; kernel mode, ROM word 0.
IRQ_VEC, 32'h8000_0004, interrupt vector (ROM word 1).
EXC_VEC, 32'h8000_0008, illegal-op vector (ROM word 2).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
Instruction  in  32  current word from instruction ROM; [25:0] jump field, [15:0] branch offset
PCSrc  in  2  from control: 00 seq, 01 branch, 10 jump, 11 jr
BranchCond  in  1  branch taken (ALU result), used only when PCSrc=01
JrTarget  in  32  rs register value for jr
IRQ  in  1  level interrupt request from timer
IllegalOp  in  1  control decoded an unsupported opcode
Stall  in  1  hold PC this cycle
PC  out  32  current PC, to ROM Address
PCPlus4  out  32  PC+4 with bit31 = PC[31], for jal/link
Kernel  out  1  PC[31]
ExcSave  out  32  value to write to $k0 ($26)
ExcWrite  out  1  regfile write-enable for $k0; also squashes current instruction's side effects
IrqTaken  out  1  interrupt accepted this cycle

Behaviour:
- Reset (sync): PC<=RESET_PC, pend<=0, holdoff<=0. Outputs follow combinationally from these values: ExcWrite=0, IrqTaken=0.
- PCPlus4 = {PC[31], PC[30:0]+4}. Arithmetic never carries into bit31.
- Branch target = {PC[31], (PCPlus4 + (sext(Instruction[15:0])<<2))[30:0]}.
- Jump target = {PCPlus4[31:28], Instruction[25:0], 2'b00}.
- jr target = JrTarget in full, including bit31. jr is the only way to leave kernel mode.
- pend register: set on any cycle with IRQ=1. Cleared on the cycle an interrupt is taken. Not cleared by Stall.
- Priority when not stalled: IllegalOp > interrupt > PCSrc path.
- IllegalOp with Kernel=0: next PC=EXC_VEC, ExcSave=PCPlus4, ExcWrite=1.
- IllegalOp with Kernel=1: ignored; next PC=PCPlus4, no save.
- Interrupt taken iff (pend|IRQ) & ~Kernel & ~holdoff & ~IllegalOp. Then next PC=IRQ_VEC, ExcSave=PC (current instruction squashed and re-executed on return), ExcWrite=1, IrqTaken=1, pend<=0.
- IRQ while Kernel=1: latched in pend, taken on the first eligible user-mode cycle.
- holdoff: set for one cycle when a jr moves PC from kernel (bit31=1) to user (bit31=0). Guarantees one user instruction executes between handlers. Cleared on the next non-stalled cycle.
- Stall=1: PC, holdoff hold; ExcWrite=0, IrqTaken=0; pend still sets on IRQ. An IllegalOp in a stalled cycle is re-evaluated next cycle.
- All outputs except PC, Kernel and PCPlus4 are combinational from current state and inputs. Latency is zero cycles to ROM Address; the next-PC update is visible one clock edge later.
- Reset mid-handler: PC returns to RESET_PC; pend and holdoff are discarded.

Test Plan:
- Reset -> PC=0x80000000, Kernel=1. Three cycles of PCSrc=00 -> PC=0x80000004, 0x80000008, 0x8000000C.
- PC=0x00000038, PCSrc=01, BranchCond=1, Instruction=0x1008FFFD -> next PC=0x00000030. With BranchCond=0 -> 0x0000003C.
- Jump 0x08000017 at PC=0x00000078 -> PC=0x0000005C. Jump 0x08000003 at PC=0x80000000 -> PC=0x8000000C, Kernel stays 1.
- User PC=0x00000050, IRQ=1 -> ExcWrite=1, ExcSave=0x00000050, IrqTaken=1, next PC=0x80000004.
- IRQ pulse while PC=0x80000090, then jr JrTarget=0x00000050 -> PC=0x00000050 executes once (holdoff), next cycle PC=0x80000004 with ExcSave=0x00000054.
- IllegalOp at user PC=0x00000020 -> PC=0x80000008, ExcSave=0x00000024. IllegalOp in kernel -> PC advances by 4, ExcWrite=0.
- Stall=1 for 2 cycles with IRQ pulse -> PC frozen, no IrqTaken. After release -> interrupt taken.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter stage: holds PC for the instruction ROM and selects the next PC.
// Also handles interrupt/exception vectoring, the kernel-mode bit and the $k0 save value.
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction,
    input  logic [1:0]  PCSrc,
    input  logic        BranchCond,
    input  logic [31:0] JrTarget,
    input  logic        IRQ,
    input  logic        IllegalOp,
    input  logic        Stall,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Kernel,
    output logic [31:0] ExcSave,
    output logic        ExcWrite,
    output logic        IrqTaken
);

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'b00,
        SRC_BRANCH = 2'b01,
        SRC_JUMP   = 2'b10,
        SRC_JR     = 2'b11
    } pc_src_e;

    logic [31:0] r_pc;
    logic        r_pend;
    logic        r_holdoff;

    logic        w_kernel;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_sum;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_path_pc;
    logic [31:0] w_next_pc;
    logic        w_exc_take;
    logic        w_irq_take;
    logic        w_leave_kernel;
    logic        w_unused;

    assign w_kernel = r_pc[31];

    // Sequential/branch arithmetic is 31 bits wide so it can never flip the mode bit.
    assign w_pc_plus4      = {r_pc[31], r_pc[30:0] + 31'd4};
    assign w_branch_sum    = w_pc_plus4 + {{14{Instruction[15]}}, Instruction[15:0], 2'b00};
    assign w_branch_target = {r_pc[31], w_branch_sum[30:0]};
    assign w_jump_target   = {w_pc_plus4[31:28], Instruction[25:0], 2'b00};

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_path_pc = w_pc_plus4;
        case (pc_src_e'(PCSrc))
            SRC_BRANCH: if (BranchCond) w_path_pc = w_branch_target;
            SRC_JUMP:   w_path_pc = w_jump_target;
            SRC_JR:     w_path_pc = JrTarget;
            default:    w_path_pc = w_pc_plus4;
        endcase
    end

    assign w_exc_take = ~Stall & IllegalOp & ~w_kernel;
    assign w_irq_take = ~Stall & ~IllegalOp & (r_pend | IRQ) & ~w_kernel & ~r_holdoff;

    always_comb begin
        w_next_pc = w_path_pc;
        if (w_exc_take)
            w_next_pc = EXC_VEC;
        else if (IllegalOp)
            w_next_pc = w_pc_plus4;     // kernel ignores illegal ops
        else if (w_irq_take)
            w_next_pc = IRQ_VEC;
    end

    // Only a jr can drop bit31, so this marks the return from a handler.
    assign w_leave_kernel = w_kernel & ~w_next_pc[31];

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_pend    <= 1'b0;
            r_holdoff <= 1'b0;
        end else begin
            if (w_irq_take)
                r_pend <= 1'b0;
            else if (IRQ)
                r_pend <= 1'b1;
            if (!Stall) begin
                r_pc      <= w_next_pc;
                r_holdoff <= w_leave_kernel;
            end
        end
    end

    assign PC       = r_pc;
    assign PCPlus4  = w_pc_plus4;
    assign Kernel   = w_kernel;
    assign ExcWrite = w_exc_take | w_irq_take;
    assign IrqTaken = w_irq_take;
    assign ExcSave  = w_exc_take ? w_pc_plus4 : r_pc;

    assign w_unused = ^{Instruction[31:26], w_branch_sum[31]};

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, hand-written multi-cycle sequences,
// and randomized cycles compared against a behavioural model of the PC rules.
module tb_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC  = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instruction;
    logic [1:0]  PCSrc;
    logic        BranchCond;
    logic [31:0] JrTarget;
    logic        IRQ;
    logic        IllegalOp;
    logic        Stall;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Kernel;
    logic [31:0] ExcSave;
    logic        ExcWrite;
    logic        IrqTaken;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .Instruction (Instruction),
        .PCSrc       (PCSrc),
        .BranchCond  (BranchCond),
        .JrTarget    (JrTarget),
        .IRQ         (IRQ),
        .IllegalOp   (IllegalOp),
        .Stall       (Stall),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .Kernel      (Kernel),
        .ExcSave     (ExcSave),
        .ExcWrite    (ExcWrite),
        .IrqTaken    (IrqTaken)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        reset       = 1'b0;
        Instruction = 32'h0;
        PCSrc       = 2'b00;
        BranchCond  = 1'b0;
        JrTarget    = 32'h0;
        IRQ         = 1'b0;
        IllegalOp   = 1'b0;
        Stall       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Reach a PC with pend and holdoff clear: jr to target-4, then one sequential step.
    task automatic goto_pc(input logic [31:0] target);
        do_reset();
        if (target != RESET_PC) begin
            PCSrc    = 2'b11;
            JrTarget = target - 32'd4;
            tick();
            idle_inputs();
            tick();
        end
        check("setup_pc", PC, target);
    endtask

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  src;
        logic        bc;
        logic [31:0] jr;
        logic        irq;
        logic        ill;
        logic        stall;
        logic [31:0] exp_next;
        logic        exp_ew;
        logic [31:0] exp_save;
        logic        exp_it;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [1:0] src, input logic bc, input logic [31:0] jr,
                       input logic irq, input logic ill, input logic stall,
                       input logic [31:0] exp_next, input logic exp_ew,
                       input logic [31:0] exp_save, input logic exp_it);
        vec_t v;
        v.name = name; v.pc = pc; v.instr = instr; v.src = src; v.bc = bc; v.jr = jr;
        v.irq = irq; v.ill = ill; v.stall = stall; v.exp_next = exp_next;
        v.exp_ew = exp_ew; v.exp_save = exp_save; v.exp_it = exp_it;
        vecs.push_back(v);
    endtask

    // Behavioural reference state
    logic [31:0] m_pc;
    bit          m_pend;
    bit          m_hold;

    function automatic logic [31:0] model_plus4(input logic [31:0] pc);
        return (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();

        // Reset state and three sequential fetches
        do_reset();
        check("rst_pc", PC, RESET_PC);
        check("rst_kernel", {31'b0, Kernel}, 32'd1);
        check("rst_excwrite", {31'b0, ExcWrite}, 32'd0);
        check("rst_irqtaken", {31'b0, IrqTaken}, 32'd0);
        check("rst_pcplus4", PCPlus4, 32'h8000_0004);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("seq_pc", PC, RESET_PC + 32'(4 * i));
        end

        // Directed single-cycle vectors
        add("br_taken",   32'h0000_0038, 32'h1008_FFFD, 2'b01, 1, 0, 0, 0, 0, 32'h0000_0030, 0, 0, 0);
        add("br_not",     32'h0000_0038, 32'h1008_FFFD, 2'b01, 0, 0, 0, 0, 0, 32'h0000_003C, 0, 0, 0);
        add("jump_user",  32'h0000_0078, 32'h0800_0017, 2'b10, 0, 0, 0, 0, 0, 32'h0000_005C, 0, 0, 0);
        add("jump_kern",  32'h8000_0000, 32'h0800_0003, 2'b10, 0, 0, 0, 0, 0, 32'h8000_000C, 0, 0, 0);
        add("br_kwrap",   32'h8000_0000, 32'h1000_FFFE, 2'b01, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
        add("seq_uwrap",  32'h7FFF_FFFC, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0);
        add("seq_kwrap",  32'hFFFF_FFFC, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0);
        add("jr_leave",   32'h8000_0040, 32'h0,         2'b11, 0, 32'h100, 0, 0, 0, 32'h0000_0100, 0, 0, 0);
        add("jr_user",    32'h0000_0100, 32'h0,         2'b11, 0, 32'h200, 0, 0, 0, 32'h0000_0200, 0, 0, 0);
        add("irq_user",   32'h0000_0050, 32'h0,         2'b00, 0, 0, 1, 0, 0, IRQ_VEC,       1, 32'h0000_0050, 1);
        add("irq_kern",   32'h8000_0020, 32'h0,         2'b00, 0, 0, 1, 0, 0, 32'h8000_0024, 0, 0, 0);
        add("ill_user",   32'h0000_0020, 32'h0,         2'b00, 0, 0, 0, 1, 0, EXC_VEC,       1, 32'h0000_0024, 0);
        add("ill_kern",   32'h8000_0010, 32'h0800_0003, 2'b10, 0, 0, 0, 1, 0, 32'h8000_0014, 0, 0, 0);
        add("ill_irq",    32'h0000_0040, 32'h0,         2'b00, 0, 0, 1, 1, 0, EXC_VEC,       1, 32'h0000_0044, 0);
        add("ill_stall",  32'h0000_0040, 32'h0,         2'b00, 0, 0, 0, 1, 1, 32'h0000_0040, 0, 0, 0);

        foreach (vecs[k]) begin
            goto_pc(vecs[k].pc);
            Instruction = vecs[k].instr;
            PCSrc       = vecs[k].src;
            BranchCond  = vecs[k].bc;
            JrTarget    = vecs[k].jr;
            IRQ         = vecs[k].irq;
            IllegalOp   = vecs[k].ill;
            Stall       = vecs[k].stall;
            #1;
            check({vecs[k].name, "_excwrite"}, {31'b0, ExcWrite}, {31'b0, vecs[k].exp_ew});
            check({vecs[k].name, "_irqtaken"}, {31'b0, IrqTaken}, {31'b0, vecs[k].exp_it});
            if (vecs[k].exp_ew)
                check({vecs[k].name, "_excsave"}, ExcSave, vecs[k].exp_save);
            tick();
            idle_inputs();
            check({vecs[k].name, "_next_pc"}, PC, vecs[k].exp_next);
        end

        // IRQ latched in kernel, jr back to user, one user instruction runs before the handler
        goto_pc(32'h8000_0090);
        IRQ = 1'b1;
        #1;
        check("hold_kirq_taken", {31'b0, IrqTaken}, 32'd0);
        tick();
        idle_inputs();
        PCSrc    = 2'b11;
        JrTarget = 32'h0000_0050;
        #1;
        check("hold_jr_taken", {31'b0, IrqTaken}, 32'd0);
        tick();
        idle_inputs();
        check("hold_user_pc", PC, 32'h0000_0050);
        #1;
        check("hold_blocks_irq", {31'b0, IrqTaken}, 32'd0);
        tick();
        check("hold_next_pc", PC, 32'h0000_0054);
        #1;
        check("hold_irq_taken", {31'b0, IrqTaken}, 32'd1);
        check("hold_excsave", ExcSave, 32'h0000_0054);
        tick();
        check("hold_vec_pc", PC, IRQ_VEC);

        // Stall freezes PC and blocks the interrupt; pend survives the stall
        goto_pc(32'h0000_0060);
        Stall = 1'b1;
        IRQ   = 1'b1;
        #1;
        check("stall1_irqtaken", {31'b0, IrqTaken}, 32'd0);
        check("stall1_excwrite", {31'b0, ExcWrite}, 32'd0);
        tick();
        IRQ = 1'b0;
        check("stall1_pc", PC, 32'h0000_0060);
        #1;
        check("stall2_irqtaken", {31'b0, IrqTaken}, 32'd0);
        tick();
        check("stall2_pc", PC, 32'h0000_0060);
        Stall = 1'b0;
        #1;
        check("unstall_irqtaken", {31'b0, IrqTaken}, 32'd1);
        check("unstall_excsave", ExcSave, 32'h0000_0060);
        tick();
        check("unstall_pc", PC, IRQ_VEC);

        // Reset mid-handler discards a pending interrupt
        goto_pc(32'h8000_0090);
        IRQ = 1'b1;
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_pc", PC, RESET_PC);
        PCSrc    = 2'b11;
        JrTarget = 32'h0000_0100;
        tick();
        idle_inputs();
        tick();
        check("midrst_user_pc", PC, 32'h0000_0104);
        #1;
        check("midrst_no_irq", {31'b0, IrqTaken}, 32'd0);

        // Randomized cycles against the behavioural model
        do_reset();
        m_pc   = RESET_PC;
        m_pend = 0;
        m_hold = 0;
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] p4, nxt, jr_hi;
            logic        kern, e_exc, e_irq;
            logic [31:0] off;
            reset       = ($urandom_range(0, 63) == 0);
            Instruction = $urandom;
            PCSrc       = 2'($urandom_range(0, 3));
            BranchCond  = 1'($urandom_range(0, 1));
            jr_hi       = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0;
            JrTarget    = jr_hi | (32'($urandom_range(0, 255)) << 2);
            IRQ         = ($urandom_range(0, 7) == 0);
            IllegalOp   = ($urandom_range(0, 15) == 0);
            Stall       = ($urandom_range(0, 7) == 0);
            #1;

            kern  = (m_pc >= 32'h8000_0000);
            p4    = model_plus4(m_pc);
            e_exc = !Stall && IllegalOp && !kern;
            e_irq = !Stall && !IllegalOp && (m_pend || IRQ) && !kern && !m_hold;
            check("rnd_pcplus4", PCPlus4, p4);
            check("rnd_kernel", {31'b0, Kernel}, {31'b0, kern});
            check("rnd_excwrite", {31'b0, ExcWrite}, {31'b0, e_exc || e_irq});
            check("rnd_irqtaken", {31'b0, IrqTaken}, {31'b0, e_irq});
            if (e_exc)
                check("rnd_excsave_exc", ExcSave, p4);
            else if (e_irq)
                check("rnd_excsave_irq", ExcSave, m_pc);

            if (reset) begin
                m_pc   = RESET_PC;
                m_pend = 0;
                m_hold = 0;
            end else if (Stall) begin
                m_pend = m_pend || IRQ;
            end else begin
                if (e_exc)
                    nxt = EXC_VEC;
                else if (IllegalOp)
                    nxt = p4;
                else if (e_irq)
                    nxt = IRQ_VEC;
                else if (PCSrc == 2'b01 && BranchCond) begin
                    off = {{16{Instruction[15]}}, Instruction[15:0]} * 32'd4;
                    nxt = (m_pc & 32'h8000_0000) | ((p4 + off) & 32'h7FFF_FFFF);
                end else if (PCSrc == 2'b10)
                    nxt = (p4 & 32'hF000_0000) | ({6'b0, Instruction[25:0]} * 32'd4);
                else if (PCSrc == 2'b11)
                    nxt = JrTarget;
                else
                    nxt = p4;
                m_hold = !IllegalOp && !e_irq && PCSrc == 2'b11 && kern && !JrTarget[31];
                m_pend = e_irq ? 1'b0 : (m_pend || IRQ);
                m_pc   = nxt;
            end
            tick();
            check("rnd_pc", PC, m_pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
